instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Fetch controller for the multicycle 16-bit RISC core, directly downstream of the PC register. On a fetch request from the main control unit it:
- latches the current PC;
- runs a request/acknowledge read on the instruction memory port;
- loads the returned word into the instruction register;
- drives the incremented PC and a one-cycle write enable back into the PC register's `in`/`en` inputs.

## Interface
Parameters:
- `ADDR_W`, 16, PC / instruction address width
- `INSTR_W`, 16, instruction word width
- `TIMEOUT_CYC`, 15, cycles in REQ without `mem_ack` before fault (used only with `FETCH_TIMEOUT_EN`)

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  input  1  rising-edge clock, shared with the PC register
- `rst`  input  1  synchronous active-high reset
- `start`  input  1  fetch request pulse from control unit
- `pc_in`  input  ADDR_W  current PC (PC register `out`)
- `mem_req`  output  1  instruction memory read request
- `mem_addr`  output  ADDR_W  read address, latched PC
- `mem_ack`  input  1  memory acknowledge, `mem_rdata` valid this cycle
- `mem_rdata`  input  INSTR_W  instruction word
- `ir`  output  INSTR_W  instruction register
- `done`  output  1  one-cycle pulse: `ir` updated
- `pc_next`  output  ADDR_W  latched PC + 1, to PC register `in`
- `pc_en`  output  1  one-cycle PC write enable, to PC register `en`
- `busy`  output  1  high in any state other than IDLE
- `fault`  output  1  sticky fetch timeout flag (constant 0 without `FETCH_TIMEOUT_EN`)

## Operation
States:
- IDLE: `start`=1 → REQ. Latch `pc_in` into `addr_q`; clear the timeout counter.
- REQ: `mem_req`=1, `mem_addr`=`addr_q`.
  - `mem_ack`=1 → capture `mem_rdata` into `ir` and go to DONE.
  - Otherwise stay in REQ and increment the counter.
- DONE: `pc_en`=1, `done`=1, `pc_next`=`addr_q`+1. Next state IDLE.
- FAULT (only with macro): `mem_req`=0 and `fault`=1. Only `rst` leaves this state.

Rules:
- `pc_next` is `addr_q + 1` modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000. It is held at this value in all states.
- `start` outside IDLE is ignored; no queueing.
- `mem_ack` is honoured only in REQ; an ack in any other state is ignored and `ir` is unchanged.
- `pc_in` changes after the latch do not affect the fetch in flight.
- `ir` holds its value until the next successful fetch.
- Reset values: state IDLE, `ir`=0, `addr_q`=0, `pc_next`=0x0001, all 1-bit outputs 0.
- `rst` mid-fetch returns the block to IDLE on that edge and drops `mem_req` the next cycle. No `pc_en` and no `done` are produced for the aborted fetch.

## Timing
- `start` is sampled at edge N. REQ is active from N+1.
- An ack in the first REQ cycle is sampled at edge N+2. `ir` is valid, and `done`/`pc_en` are high, in cycle N+2 → N+3. The PC register loads `pc_next` at edge N+3.
- Minimum `start`-to-`done` latency is 2 cycles; each wait cycle adds 1.
- `mem_req` is registered and stays high until the edge that samples `mem_ack`.
- Back-to-back fetches: the next accepted `start` is at the first edge in IDLE, which is one cycle after DONE.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) counts REQ cycles.
  - When the counter reaches TIMEOUT_CYC with no ack, the next state is FAULT.
  - An ack arriving on that same edge wins, and the FSM goes to DONE.
- `FETCH_TIMEOUT_EN` undefined: no counter and no FAULT state. REQ waits indefinitely and `fault` is tied to 0.

## Test plan
- Reset, then `pc_in`=0x0010, `start` pulse, ack on the first REQ cycle with `mem_rdata`=0xA5C3 → `ir`=0xA5C3, `pc_next`=0x0011, `pc_en` and `done` high for exactly 1 cycle, 2 cycles after `start`.
- `pc_in`=0xFFFF, 3 wait cycles then ack with 0x1234 → `mem_addr`=0xFFFF throughout REQ, `pc_next`=0x0000, `done` 5 cycles after `start`.
- `start` asserted continuously, plus `pc_in` changed to 0x0040 during REQ → one fetch per 3 cycles, and the in-flight fetch still uses the latched address.
- `mem_ack`=1 while IDLE with `mem_rdata`=0xFFFF → `ir` unchanged, `done`=0, `pc_en`=0.
- `rst` asserted during REQ → next cycle IDLE, `mem_req`=0, `ir`=0x0000, no `pc_en` pulse.
- With `FETCH_TIMEOUT_EN`: never ack → `fault`=1 after 15 REQ cycles, `mem_req`=0, `start` ignored until `rst`. Ack on cycle 15 → normal DONE with `fault`=0.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: latches PC, runs a req/ack memory read, loads IR, pulses PC update.
// Optional REQ timeout with sticky fault enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               done,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_en,
  output logic               busy,
  output logic               fault
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("instr_fetch_ctrl: TIMEOUT_CYC must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_e;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
`endif

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                latch_c;
  logic                capture_c;

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0]    cnt_q;
  logic                expire_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an ack on the expiry edge still completes the fetch
  always_comb begin
    state_d   = state_q;
    latch_c   = 1'b0;
    capture_c = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    expire_c  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_c = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          capture_c = 1'b1;
          state_d   = S_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (expire_c) begin
          state_d = S_FAULT;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      pc_next <= ADDR_W'(1);
      ir      <= '0;
      mem_req <= 1'b0;
      done    <= 1'b0;
      pc_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (latch_c) begin
        addr_q  <= pc_in;
        pc_next <= pc_in + ADDR_W'(1);
      end
      if (capture_c) ir <= mem_rdata;
      mem_req <= (state_d == S_REQ);
      done    <= (state_d == S_DONE);
      pc_en   <= (state_d == S_DONE);
      busy    <= (state_d != S_IDLE);
    end
  end

  assign mem_addr = addr_q;

`ifdef FETCH_TIMEOUT_EN
  // Counts REQ cycles without an ack since the fetch was accepted
  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= '0;
    else if (latch_c)                     cnt_q <= '0;
    else if (state_q == S_REQ && !mem_ack) cnt_q <= cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) fault <= 1'b0;
    else     fault <= (state_d == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized self-checking bench for instr_fetch_ctrl against a transaction-level expectation model.
module tb_instr_fetch_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned IW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] pc_in;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] ir;
  logic          done;
  logic [AW-1:0] pc_next;
  logic          pc_en;
  logic          busy;
  logic          fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last successfully fetched word and the PC-increment value
  logic [IW-1:0] exp_ir;
  logic [AW-1:0] exp_pc_next;

  instr_fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .done(done), .pc_next(pc_next), .pc_en(pc_en), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
    check({tag, ".pc_en"},   32'(pc_en),   32'd0);
    check({tag, ".ir"},      32'(ir),      32'(exp_ir));
    check({tag, ".pc_next"}, 32'(pc_next), 32'(exp_pc_next));
    check({tag, ".fault"},   32'(fault),   32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    step();
    rst = 1'b0;
    exp_ir      = '0;
    exp_pc_next = AW'(1);
  endtask

  // One complete fetch: accept, 'waits' ack-less REQ cycles, ack, DONE, back to IDLE.
  task automatic fetch(input logic [AW-1:0] pc, input int waits, input logic [IW-1:0] data,
                       input bit noisy);
    start = 1'b1; pc_in = pc; mem_ack = 1'b0; mem_rdata = IW'($urandom);
    step();
    exp_pc_next = pc + AW'(1);
    for (int w = 0; w <= waits; w++) begin
      check("req.mem_req",  32'(mem_req),  32'd1);
      check("req.mem_addr", 32'(mem_addr), 32'(pc));
      check("req.done",     32'(done),     32'd0);
      check("req.pc_en",    32'(pc_en),    32'd0);
      check("req.busy",     32'(busy),     32'd1);
      check("req.ir",       32'(ir),       32'(exp_ir));
      check("req.pc_next",  32'(pc_next),  32'(exp_pc_next));
      check("req.fault",    32'(fault),    32'd0);
      start = noisy ? 1'($urandom) : 1'b0;
      pc_in = noisy ? AW'($urandom) : pc;
      if (w == waits) begin
        mem_ack = 1'b1; mem_rdata = data;
      end else begin
        mem_ack = 1'b0; mem_rdata = IW'($urandom);
      end
      step();
    end
    exp_ir = data;
    check("done.done",    32'(done),    32'd1);
    check("done.pc_en",   32'(pc_en),   32'd1);
    check("done.ir",      32'(ir),      32'(exp_ir));
    check("done.pc_next", 32'(pc_next), 32'(exp_pc_next));
    check("done.mem_req", 32'(mem_req), 32'd0);
    check("done.busy",    32'(busy),    32'd1);
    start     = noisy ? 1'b1 : 1'b0;
    mem_ack   = noisy ? 1'($urandom) : 1'b0;
    mem_rdata = IW'($urandom);
    step();
    check_idle("post_done");
    start = 1'b0; mem_ack = 1'b0;
  endtask

  // Reset mid-fetch: back to IDLE with IR cleared and no completion pulse.
  task automatic abort_fetch(input logic [AW-1:0] pc, input int waits);
    start = 1'b1; pc_in = pc; mem_ack = 1'b0;
    step();
    start = 1'b0;
    for (int w = 0; w < waits; w++) step();
    check("abort.mem_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ack = 1'($urandom); mem_rdata = IW'($urandom);
    step();
    rst = 1'b0; mem_ack = 1'b0;
    exp_ir = '0; exp_pc_next = AW'(1);
    check_idle("abort");
    step();
    check_idle("abort_next");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_ir = '0; exp_pc_next = AW'(1);
    step();
    rst = 1'b0;
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check_idle("rst");

    fetch(16'h0010, 0, 16'hA5C3, 1'b0);
    fetch(16'hFFFF, 3, 16'h1234, 1'b0);
    check("wrap.pc_next", 32'(pc_next), 32'h0000);

    // Ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    check_idle("idle_ack");
    mem_ack = 1'b0;

    // Continuous start: one fetch every three cycles, latched address survives pc_in change
    start = 1'b1; pc_in = 16'h0020; mem_ack = 1'b0;
    step();
    check("b2b.addr0", 32'(mem_addr), 32'h0020);
    pc_in = 16'h0040; mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    check("b2b.done0", 32'(done), 32'd1);
    check("b2b.ir0",   32'(ir), 32'h1111);
    check("b2b.pcn0",  32'(pc_next), 32'h0021);
    mem_ack = 1'b0;
    step();
    check("b2b.gap_done", 32'(done), 32'd0);
    check("b2b.gap_busy", 32'(busy), 32'd0);
    step();
    check("b2b.req1",  32'(mem_req), 32'd1);
    check("b2b.addr1", 32'(mem_addr), 32'h0040);
    check("b2b.pcn1",  32'(pc_next), 32'h0041);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    check("b2b.done1", 32'(done), 32'd1);
    check("b2b.ir1",   32'(ir), 32'h2222);
    start = 1'b0; mem_ack = 1'b0;
    exp_ir = 16'h2222; exp_pc_next = 16'h0041;
    step();
    check_idle("b2b.end");

    abort_fetch(16'h0300, 2);

`ifdef FETCH_TIMEOUT_EN
    start = 1'b1; pc_in = 16'h0100; mem_ack = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= int'(TO); i++) begin
      check("to.req",   32'(mem_req), 32'd1);
      check("to.fault", 32'(fault),   32'd0);
      step();
    end
    check("to.fault_set", 32'(fault),   32'd1);
    check("to.req_drop",  32'(mem_req), 32'd0);
    check("to.busy",      32'(busy),    32'd1);
    start = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to.sticky",  32'(fault),   32'd1);
      check("to.no_req",  32'(mem_req), 32'd0);
      check("to.no_done", 32'(done),    32'd0);
    end
    start = 1'b0; mem_ack = 1'b0;
    do_reset();
    check_idle("to.rst");
    fetch(16'h0200, int'(TO) - 1, 16'hBEEF, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        abort_fetch(AW'($urandom), int'($urandom_range(0, 3)));
      end else if (r < 3) begin
        start = 1'b0; mem_ack = 1'($urandom); mem_rdata = IW'($urandom); pc_in = AW'($urandom);
        step();
        check_idle("rand_idle");
        mem_ack = 1'b0;
      end else begin
        fetch(AW'($urandom), int'($urandom_range(0, 6)), IW'($urandom), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
